// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Slot layout and forwarding-select encodings used by hazard_ctrl and fwd_sel.
package hazard_ctrl_pkg;

   localparam int RA_W = 5;
   localparam int FW_W = 2;

   localparam logic [FW_W-1:0] FW_REG = 2'b00;
   localparam logic [FW_W-1:0] FW_MEM = 2'b01;
   localparam logic [FW_W-1:0] FW_WB  = 2'b10;

   typedef struct packed {
      logic            wreg;
      logic            m2reg;
      logic [RA_W-1:0] dest;
   } slot_t;

   // True when the slot will write a non-zero register equal to src.
   function automatic logic slot_hit(slot_t s, logic [RA_W-1:0] src);
      return s.wreg && (s.dest != '0) && (s.dest == src);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX-side bundle between the pipeline datapath and hazard_ctrl.
// master = datapath, slave = hazard controller.
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic [RA_W-1:0] id_rs;
   logic [RA_W-1:0] id_rt;
   logic            id_use_rs;
   logic            id_use_rt;
   logic [RA_W-1:0] id_destR;
   logic            id_wreg;
   logic            id_m2reg;
   logic            ex_branch;
   logic            ex_zero;

   logic [FW_W-1:0] id_FWA;
   logic [FW_W-1:0] id_FWB;
   logic            pc_wen;
   logic            ifid_wen;
   logic            ifid_flush;
   logic            idex_bubble;
   logic            pc_sel_branch;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
      output id_destR, id_wreg, id_m2reg,
      output ex_branch, ex_zero,
      input  id_FWA, id_FWB, pc_wen, ifid_wen,
      input  ifid_flush, idex_bubble, pc_sel_branch
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
      input  id_destR, id_wreg, id_m2reg,
      input  ex_branch, ex_zero,
      output id_FWA, id_FWB, pc_wen, ifid_wen,
      output ifid_flush, idex_bubble, pc_sel_branch
   );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Compares one ID source register against the EX and MEM scoreboard slots.
// Yields the forwarding select and a load-in-EX hit for the stall detector.
module fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [RA_W-1:0] src_i,
   input  logic            use_i,
   input  slot_t           ex_i,
   input  slot_t           mem_i,
   output logic [FW_W-1:0] sel_o,
   output logic            ld_hit_o
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit   = use_i & slot_hit(ex_i, src_i);
   assign mem_hit  = use_i & slot_hit(mem_i, src_i);
   assign ld_hit_o = ex_hit & ex_i.m2reg;

   // EX is the newer producer, so it is tested first.
   always_comb begin
      sel_o = FW_REG;
      priority case (1'b1)
         (ex_hit & ~ex_i.m2reg): sel_o = FW_MEM;
         mem_hit:                sel_o = FW_WB;
         default:                sel_o = FW_REG;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow scoreboard, registered forwarding, stall and flush.
// Optional HAZARD_STATS_EN adds stall_cnt/flush_cnt event counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   slot_t ex_q, mem_q, wb_q, ex_d;
   logic [FW_W-1:0] fwa_q, fwb_q, fwa_d, fwb_d;
   logic [FW_W-1:0] sel_a, sel_b;
   logic ld_hit_a, ld_hit_b;
   logic taken, ld_use, stall, bubble;
   logic unused_wb;

   fwd_sel u_fwd_a (
      .src_i    (hz.id_rs),
      .use_i    (hz.id_use_rs),
      .ex_i     (ex_q),
      .mem_i    (mem_q),
      .sel_o    (sel_a),
      .ld_hit_o (ld_hit_a)
   );

   fwd_sel u_fwd_b (
      .src_i    (hz.id_rt),
      .use_i    (hz.id_use_rt),
      .ex_i     (ex_q),
      .mem_i    (mem_q),
      .sel_o    (sel_b),
      .ld_hit_o (ld_hit_b)
   );

   // A taken branch discards the ID instruction, so it overrides the stall.
   assign taken  = hz.ex_branch & hz.ex_zero;
   assign ld_use = ld_hit_a | ld_hit_b;
   assign stall  = ld_use & ~taken;
   assign bubble = taken | ld_use;

   assign hz.pc_wen        = ~stall;
   assign hz.ifid_wen      = ~stall;
   assign hz.ifid_flush    = taken;
   assign hz.idex_bubble   = bubble;
   assign hz.pc_sel_branch = taken;
   assign hz.id_FWA        = fwa_q;
   assign hz.id_FWB        = fwb_q;

   always_comb begin
      ex_d  = '0;
      fwa_d = FW_REG;
      fwb_d = FW_REG;
      if (!bubble) begin
         ex_d.wreg  = hz.id_wreg;
         ex_d.m2reg = hz.id_m2reg;
         ex_d.dest  = hz.id_destR;
         fwa_d      = sel_a;
         fwb_d      = sel_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         fwa_q <= FW_REG;
         fwb_q <= FW_REG;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
         fwa_q <= fwa_d;
         fwb_q <= fwb_d;
      end
   end

   // WB slot mirrors the pipeline but no longer feeds any hazard decision.
   assign unused_wb = ^wb_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (taken) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl driven by short MIPS instruction streams.
// Expected per-cycle outputs are queued at drive time and compared mid-cycle.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .hz        (hz)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   typedef struct {
      logic [4:0] rs, rt, dst;
      logic       urs, urt, w, m;
   } ins_t;

   typedef struct {
      string      tag;
      logic [1:0] fwa, fwb;
      logic       pcw, ifw, flush, bub, psel;
   } exp_t;

   exp_t exp_q[$];

   localparam int NRM = 0;
   localparam int STL = 1;
   localparam int BRN = 2;

   function automatic ins_t nop();
      ins_t i;
      i = '{rs: 0, rt: 0, dst: 0, urs: 0, urt: 0, w: 0, m: 0};
      return i;
   endfunction

   function automatic ins_t alu(int d, int s, int t);
      ins_t i;
      i = '{rs: 5'(s), rt: 5'(t), dst: 5'(d), urs: 1, urt: 1, w: 1, m: 0};
      return i;
   endfunction

   function automatic ins_t imm(int d, int s, int t);
      ins_t i;
      i = '{rs: 5'(s), rt: 5'(t), dst: 5'(d), urs: 1, urt: 0, w: 1, m: 0};
      return i;
   endfunction

   function automatic ins_t ld(int d, int s);
      ins_t i;
      i = '{rs: 5'(s), rt: 5'(d), dst: 5'(d), urs: 1, urt: 0, w: 1, m: 1};
      return i;
   endfunction

   function automatic exp_t ex(string tag, int a, int b, int kind);
      exp_t e;
      e.tag   = tag;
      e.fwa   = 2'(a);
      e.fwb   = 2'(b);
      e.pcw   = (kind != STL);
      e.ifw   = (kind != STL);
      e.flush = (kind == BRN);
      e.bub   = (kind != NRM);
      e.psel  = (kind == BRN);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] req);
      n_chk++;
      if (obs === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, req);
   endtask

   // Drives one ID cycle, then checks the outputs seen during that cycle.
   task automatic cyc(exp_t e, ins_t i, logic br = 0, logic zr = 0);
      exp_t r;
      hz.id_rs     = i.rs;
      hz.id_rt     = i.rt;
      hz.id_use_rs = i.urs;
      hz.id_use_rt = i.urt;
      hz.id_destR  = i.dst;
      hz.id_wreg   = i.w;
      hz.id_m2reg  = i.m;
      hz.ex_branch = br;
      hz.ex_zero   = zr;
      exp_q.push_back(e);
      @(negedge clk);
      r = exp_q.pop_front();
      chk({r.tag, ".fwa"},   32'(hz.id_FWA),        32'(r.fwa));
      chk({r.tag, ".fwb"},   32'(hz.id_FWB),        32'(r.fwb));
      chk({r.tag, ".pcw"},   32'(hz.pc_wen),        32'(r.pcw));
      chk({r.tag, ".ifw"},   32'(hz.ifid_wen),      32'(r.ifw));
      chk({r.tag, ".flush"}, 32'(hz.ifid_flush),    32'(r.flush));
      chk({r.tag, ".bub"},   32'(hz.idex_bubble),   32'(r.bub));
      chk({r.tag, ".psel"},  32'(hz.pc_sel_branch), 32'(r.psel));
      @(posedge clk);
      #1;
   endtask

   initial begin
      hz.id_rs     = '0;
      hz.id_rt     = '0;
      hz.id_use_rs = 1'b0;
      hz.id_use_rt = 1'b0;
      hz.id_destR  = '0;
      hz.id_wreg   = 1'b0;
      hz.id_m2reg  = 1'b0;
      hz.ex_branch = 1'b0;
      hz.ex_zero   = 1'b0;
      @(posedge clk);
      #1;
      cyc(ex("rst", 0, 0, NRM), nop());
      rst = 1'b0;
      cyc(ex("rst1", 0, 0, NRM), nop());

      // EX-slot forwarding to operand A
      cyc(ex("t1_add", 0, 0, NRM), alu(3, 1, 2));
      cyc(ex("t1_sub", 0, 0, NRM), alu(4, 3, 5));
      cyc(ex("t1_ex",  1, 0, NRM), nop());
      cyc(ex("t1_n1",  0, 0, NRM), nop());
      cyc(ex("t1_n2",  0, 0, NRM), nop());

      // MEM-slot forwarding to operand B
      cyc(ex("t2_add", 0, 0, NRM), alu(3, 1, 2));
      cyc(ex("t2_nop", 0, 0, NRM), nop());
      cyc(ex("t2_or",  0, 0, NRM), alu(6, 7, 3));
      cyc(ex("t2_ex",  0, 2, NRM), nop());
      cyc(ex("t2_n1",  0, 0, NRM), nop());
      cyc(ex("t2_n2",  0, 0, NRM), nop());

      // Load-use: one stall, then WB forwarding on both operands
      cyc(ex("t3_lw",   0, 0, NRM), ld(8, 9));
      cyc(ex("t3_stl",  0, 0, STL), alu(10, 8, 8));
      cyc(ex("t3_and",  0, 0, NRM), alu(10, 8, 8));
      cyc(ex("t3_ex",   2, 2, NRM), nop());
      cyc(ex("t3_n1",   0, 0, NRM), nop());
      cyc(ex("t3_n2",   0, 0, NRM), nop());
`ifdef HAZARD_STATS_EN
      chk("t3_stall_cnt", stall_cnt, 32'd1);
`endif

      // Register 0 never forwards or stalls; untaken branch is inert
      cyc(ex("t4_add0", 0, 0, NRM), alu(0, 1, 2));
      cyc(ex("t4_sub",  0, 0, NRM), alu(4, 0, 0));
      cyc(ex("t4_lw0",  0, 0, NRM), ld(0, 9), 1'b1, 1'b0);
      cyc(ex("t4_rd0",  0, 0, NRM), alu(5, 0, 0), 1'b0, 1'b1);
      cyc(ex("t4_ex",   0, 0, NRM), nop());
      cyc(ex("t4_n1",   0, 0, NRM), nop());

      // Taken branch overrides a pending load-use stall
      cyc(ex("t5_lw",  0, 0, NRM), ld(8, 9));
      cyc(ex("t5_br",  0, 0, BRN), alu(10, 8, 8), 1'b1, 1'b1);
      cyc(ex("t5_n0",  0, 0, NRM), nop());
      cyc(ex("t5_n1",  0, 0, NRM), nop());
      cyc(ex("t5_n2",  0, 0, NRM), nop());
`ifdef HAZARD_STATS_EN
      chk("t5_flush_cnt", flush_cnt, 32'd1);
      chk("t5_stall_cnt", stall_cnt, 32'd1);
`endif

      // Priority of EX over MEM, and immediate-only rt is ignored
      cyc(ex("t7_a1",  0, 0, NRM), alu(3, 1, 2));
      cyc(ex("t7_a2",  0, 0, NRM), alu(3, 1, 2));
      cyc(ex("t7_sub", 0, 0, NRM), alu(4, 3, 3));
      cyc(ex("t7_ex",  1, 1, NRM), imm(7, 1, 4));
      cyc(ex("t7_imm", 0, 0, NRM), nop());
      cyc(ex("t7_n1",  0, 0, NRM), nop());
      cyc(ex("t7_n2",  0, 0, NRM), nop());

      // Reset during a stall clears the scoreboard and counters
      cyc(ex("t6_lw",  0, 0, NRM), ld(8, 9));
      rst = 1'b1;
      cyc(ex("t6_stl", 0, 0, STL), alu(10, 8, 8));
      rst = 1'b0;
      cyc(ex("t6_and", 0, 0, NRM), alu(10, 8, 8));
      cyc(ex("t6_ex",  0, 0, NRM), nop());
      cyc(ex("t6_n1",  0, 0, NRM), nop());
`ifdef HAZARD_STATS_EN
      chk("t6_stall_cnt", stall_cnt, 32'd0);
      chk("t6_flush_cnt", flush_cnt, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
